// File: rtl/aes_io_ctrl.sv
// aes_io_ctrl: word-serial front end for a 128-bit AES core.
// Collects 4 key words and 4 plaintext words (MS word first), launches the
// core, waits for its result with a bounded timeout, then streams the
// ciphertext out as 4 words (MS word first) with valid/ready handshaking.
module aes_io_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_pt,
  input  logic         core_done,
  input  logic [127:0] core_ct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         busy,
  output logic         timeout_err
);

  localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

  state_t        state;
  logic [2:0]    wcnt;
  logic [1:0]    k;
  logic [1:0]    k_nx;
  logic [TW-1:0] tcnt;
  logic [127:0]  result;
  logic          in_xfer;
  logic          out_xfer;

  assign k_nx     = k + 2'd1;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Job sequencer: load words, pulse the core, wait with timeout, drain result.
  // All handshake/status outputs are registered and updated with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      wcnt        <= '0;
      k           <= '0;
      tcnt        <= '0;
      core_key    <= '0;
      core_pt     <= '0;
      result      <= '0;
      in_ready    <= 1'b1;
      core_start  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      core_start  <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        LOAD: begin
          if (in_xfer) begin
            // Words 0..3 fill the key, 4..7 the plaintext; word 0 lands in bits 127:96.
            if (!wcnt[2]) begin
              core_key[{~wcnt[1:0], 5'd0} +: 32] <= in_data;
            end else begin
              core_pt[{~wcnt[1:0], 5'd0} +: 32] <= in_data;
            end
            wcnt <= wcnt + 3'd1;
            if (wcnt == 3'd7) begin
              state      <= START;
              in_ready   <= 1'b0;
              busy       <= 1'b1;
              core_start <= 1'b1;
            end
          end
        end
        START: begin
          state <= WAIT;
          tcnt  <= '0;
        end
        WAIT: begin
          // A done on the last allowed cycle still counts as success.
          if (core_done) begin
            result    <= core_ct;
            out_data  <= core_ct[127:96];
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            k         <= '0;
            state     <= DRAIN;
          end else if (tcnt == TLAST) begin
            timeout_err <= 1'b1;
            wcnt        <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            state       <= LOAD;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            if (k == 2'd3) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              k         <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= LOAD;
            end else begin
              k        <= k_nx;
              out_data <= result[{~k_nx, 5'd0} +: 32];
              out_last <= (k_nx == 2'd3);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_io_ctrl.sv
// Testbench for aes_io_ctrl: table of jobs plus randomized jobs, a simple
// behavioural AES-core stand-in, and hand-written reset/spurious-done sequences.
module tb_aes_io_ctrl;

  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         core_start;
  logic [127:0] core_key;
  logic [127:0] core_pt;
  logic         core_done;
  logic [127:0] core_ct;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         timeout_err;

  logic mdl_done  = 1'b0;
  logic spur_done = 1'b0;
  assign core_done = mdl_done | spur_done;

  aes_io_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_start(core_start), .core_key(core_key), .core_pt(core_pt),
    .core_done(core_done), .core_ct(core_ct),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           delay;      // core latency in cycles after core_start, 0 = never
    bit           gap;        // random in_valid gaps
    bit           rnd;        // random out_ready
    int           stall_word; // out word index held back, -1 = none
    int           stall_len;
    bit           exp_to;     // job expected to end in timeout
  } job_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int delay = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int starts = 0, start_cyc = -1, terrs = 0, terr_cyc = -1, ov_cyc = -1;
  bit ov_seen = 1'b0;
  logic [31:0] oq_data[$];
  logic        oq_last[$];
  bit          stall_prev = 1'b0;
  logic [31:0] prev_d = '0;
  logic        prev_l = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wsel(input logic [127:0] v, input int i);
    return 32'(v >> (96 - 32 * i));
  endfunction

  function automatic job_t mk(input logic [127:0] key, input logic [127:0] pt,
                              input logic [127:0] ct, input int dly, input bit gap,
                              input bit rnd, input int sw, input int sl, input bit to);
    job_t j;
    j.key = key; j.pt = pt; j.ct = ct; j.delay = dly; j.gap = gap; j.rnd = rnd;
    j.stall_word = sw; j.stall_len = sl; j.exp_to = to;
    return j;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Offer junk words while the block is busy; withdraw as soon as it is ready.
  task automatic junk();
    if (in_ready) begin
      in_valid = 1'b0;
    end else begin
      in_valid = 1'b1;
      in_data  = $urandom;
    end
  endtask

  task automatic clear_stats();
    starts = 0; terrs = 0; ov_seen = 1'b0;
    start_cyc = -1; terr_cyc = -1; ov_cyc = -1; done_cyc = -1;
    oq_data.delete(); oq_last.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Core stand-in: returns the configured ciphertext 'delay' cycles after core_start.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      done_cnt = 0;
      mdl_done = 1'b0;
    end else begin
      mdl_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          mdl_done = 1'b1;
          done_cyc = cyc;
        end
      end
      if (core_start && delay > 0) done_cnt = delay;
    end
  end

  // Output monitor: event counts, output word log, hold-under-backpressure check.
  initial forever begin
    @(negedge clk);
    #2;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (core_start) begin starts++; start_cyc = cyc; end
      if (timeout_err) begin terrs++; terr_cyc = cyc; end
      if (out_valid && !ov_seen) begin ov_seen = 1'b1; ov_cyc = cyc; end
      if (stall_prev && out_valid) begin
        chkw("hold_data", out_data, prev_d);
        chkb("hold_last", out_last, prev_l);
      end
      if (out_valid && out_ready) begin
        oq_data.push_back(out_data);
        oq_last.push_back(out_last);
      end
      stall_prev = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
    end
  end

  task automatic run_job(input job_t j);
    logic [31:0] w[8];
    logic [31:0] cw[4];
    int idx, n, acc_cyc, got, stall;
    bit irdy_low;
    for (int i = 0; i < 4; i++) begin
      w[i]     = wsel(j.key, i);
      w[i + 4] = wsel(j.pt, i);
      cw[i]    = wsel(j.ct, i);
    end
    clear_stats();
    delay = j.delay;
    core_ct = j.ct;
    out_ready = 1'b1;
    idx = 0; n = 0; acc_cyc = -1;
    while (idx < 8 && n < 400) begin
      in_valid = j.gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? w[idx] : $urandom;
      if (in_valid && in_ready) begin idx++; acc_cyc = cyc; end
      step();
      n++;
    end
    in_valid = 1'b0;
    chki("load_words", idx, 8);
    if (idx < 8) return;
    junk();
    chkb("start_latency", core_start, 1'b1);
    chk("core_key", core_key, {w[0], w[1], w[2], w[3]});
    chk("core_pt", core_pt, {w[4], w[5], w[6], w[7]});
    chkb("busy_start", busy, 1'b1);
    chkb("in_ready_start", in_ready, 1'b0);
    n = 0;
    while (!out_valid && !timeout_err && n < TIMEOUT + 40) begin
      junk();
      step();
      n++;
    end
    if (j.exp_to) begin
      chkb("timeout_seen", timeout_err, 1'b1);
      chkb("timeout_no_ov", out_valid, 1'b0);
      junk();
      step();
      chkb("in_ready_after_to", in_ready, 1'b1);
      in_valid = 1'b0;
      repeat (10) step();
      chki("timeout_pulses", terrs, 1);
      chki("timeout_latency", terr_cyc - start_cyc, TIMEOUT + 1);
      chki("start_cycle", start_cyc - acc_cyc, 1);
      chki("start_count", starts, 1);
      chkb("no_out_valid", ov_seen, 1'b0);
      chkb("busy_after_to", busy, 1'b0);
    end else begin
      chkb("out_valid_seen", out_valid, 1'b1);
      got = 0; stall = j.stall_len; irdy_low = 1'b1; n = 0;
      while (got < 4 && n < 300) begin
        if (in_ready) irdy_low = 1'b0;
        if (out_valid && got == j.stall_word && stall > 0) begin
          out_ready = 1'b0;
          stall--;
          chkw("stall_word", out_data, cw[got]);
        end else begin
          out_ready = j.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (out_valid && out_ready) got++;
        junk();
        step();
        n++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chki("out_words", got, 4);
      chkb("in_ready_after_drain", in_ready, 1'b1);
      chkb("in_ready_low_in_drain", irdy_low, 1'b1);
      chkb("out_valid_after_drain", out_valid, 1'b0);
      chki("out_latency", ov_cyc - done_cyc, 1);
      chki("start_cycle", start_cyc - acc_cyc, 1);
      chki("start_count", starts, 1);
      chki("no_timeout", terrs, 0);
      chki("out_log_size", oq_data.size(), 4);
      for (int i = 0; i < 4 && i < oq_data.size(); i++) begin
        chkw($sformatf("out_data%0d", i), oq_data[i], cw[i]);
        chkb($sformatf("out_last%0d", i), oq_last[i], (i == 3));
      end
      chk("key_stable", core_key, {w[0], w[1], w[2], w[3]});
      chk("pt_stable", core_pt, {w[4], w[5], w[6], w[7]});
    end
    repeat (2) step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t jobs[6];
    job_t jr;
    logic [127:0] fk, fp, fc;
    logic [31:0] pw[5];
    int idx, n;
    fk = 128'h000102030405060708090a0b0c0d0e0f;
    fp = 128'h00112233445566778899aabbccddeeff;
    fc = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    jobs[0] = mk(fk, fp, fc, 20, 1'b0, 1'b0, -1, 0, 1'b0);
    jobs[1] = mk(fk, fp, fc, 20, 1'b1, 1'b0, -1, 0, 1'b0);
    jobs[2] = mk(fk, fp, fc, 20, 1'b0, 1'b0,  2, 5, 1'b0);
    jobs[3] = mk(fk, fp, fc,  0, 1'b0, 1'b0, -1, 0, 1'b1);
    jobs[4] = mk(fk, fp, fc, TIMEOUT, 1'b0, 1'b0, -1, 0, 1'b0);
    jobs[5] = mk({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, 1, 1'b1, 1'b1, 1, 3, 1'b0);

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; core_ct = '0;
    repeat (3) step();
    chkb("rst_core_start", core_start, 1'b0);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_out_last", out_last, 1'b0);
    chkw("rst_out_data", out_data, 32'h0);
    chkb("rst_timeout_err", timeout_err, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();
    chkb("rst_in_ready", in_ready, 1'b1);
    chk("rst_core_key", core_key, 128'h0);
    chk("rst_core_pt", core_pt, 128'h0);

    for (int t = 0; t < 6; t++) run_job(jobs[t]);

    // Spurious core_done while idle must be ignored.
    clear_stats();
    core_ct = {$urandom, $urandom, $urandom, $urandom};
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    repeat (3) step();
    chkb("spur_no_ov", ov_seen, 1'b0);
    chkb("spur_busy", busy, 1'b0);
    chkb("spur_in_ready", in_ready, 1'b1);

    // Reset after 5 accepted words, then a fresh job.
    clear_stats();
    delay = 20;
    for (int i = 0; i < 5; i++) pw[i] = $urandom;
    idx = 0; n = 0;
    while (idx < 5 && n < 50) begin
      in_valid = 1'b1;
      in_data = pw[idx];
      if (in_ready) idx++;
      step();
      n++;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("midrst_key", core_key, 128'h0);
    chk("midrst_pt", core_pt, 128'h0);
    chkb("midrst_in_ready", in_ready, 1'b1);
    repeat (30) step();
    chki("midrst_no_start", starts, 0);
    chkb("midrst_no_ov", ov_seen, 1'b0);
    run_job(mk(128'hfedcba9876543210_0123456789abcdef, 128'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0,
               128'h3ad77bb40d7a3660a89ecaf32466ef97, 7, 1'b0, 1'b0, -1, 0, 1'b0));

    // Randomized jobs.
    for (int t = 0; t < 4; t++) begin
      jr = mk({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(1, TIMEOUT), 1'b1, 1'b1,
              $urandom_range(0, 3), $urandom_range(0, 6), 1'b0);
      run_job(jr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_io_ctrl.md
AES_IO_CTRL -- requirements
Module: aes_io_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles spent in WAIT for core_done before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream word available.
REQ-005 in_ready  output  1  block accepts a word this cycle.
REQ-006 in_data  input  32  upstream word; 4 key words then 4 plaintext words, most-significant word first.
REQ-007 core_start  output  1  one-cycle pulse that launches the AES core.
REQ-008 core_key  output  128  cipher key presented to the core.
REQ-009 core_pt  output  128  plaintext block presented to the core.
REQ-010 core_done  input  1  one-cycle pulse; core_ct is valid in that cycle.
REQ-011 core_ct  input  128  ciphertext from the core.
REQ-012 out_valid  output  1  downstream word available.
REQ-013 out_ready  input  1  downstream accepts the word.
REQ-014 out_data  output  32  ciphertext word, most-significant word first.
REQ-015 out_last  output  1  high with the 4th (final) ciphertext word.
REQ-016 busy  output  1  high in every state except LOAD.
REQ-017 timeout_err  output  1  one-cycle pulse on a WAIT abort.

Function
REQ-018 The FSM SHALL have four states: LOAD, START, WAIT, DRAIN.
REQ-019 LOAD: in_ready=1; a transfer occurs when in_valid && in_ready; 3-bit word counter increments per transfer.
REQ-020 Word n (n=0..3) SHALL be written to core_key[127-32n -: 32], and word n (n=4..7) to core_pt[127-32(n-4) -: 32].
REQ-021 On the transfer of word 7, the counter SHALL wrap to 0 and the FSM SHALL move to START on the next cycle.
REQ-022 START: core_start=1 for exactly one cycle, then WAIT.
REQ-023 in_ready SHALL be 0 outside LOAD, and no word is consumed there regardless of in_valid.
REQ-024 core_key and core_pt SHALL be written only in LOAD and SHALL remain stable from START until the next accepted word.
REQ-025 WAIT: a timeout counter starts at 0 on entry and increments each cycle.
REQ-026 WAIT + core_done: capture core_ct into a 128-bit result register and move to DRAIN.
REQ-027 WAIT, counter reaching TIMEOUT-1 without core_done: pulse timeout_err, discard the job, and return to LOAD with the word counter at 0.
REQ-028 If core_done and the timeout condition coincide, core_done SHALL win: no error, and the FSM moves to DRAIN.
REQ-029 core_done SHALL be ignored in LOAD, START and DRAIN.
REQ-030 DRAIN: out_valid=1 and out_data = result[127-32k -: 32] for k = 0..3; out_last = (k==3).
REQ-031 k SHALL advance only on out_valid && out_ready, and out_data/out_last SHALL hold stable while out_ready=0.
REQ-032 The transfer with out_last=1 SHALL return the FSM to LOAD with k=0, and in_ready SHALL rise the next cycle.
REQ-033 Latency: core_start SHALL assert exactly 1 cycle after the cycle in which word 7 is accepted, and out_valid SHALL assert exactly 1 cycle after core_done.

Reset
REQ-034 Reset SHALL put the FSM in LOAD with the word counter, k and the timeout counter at 0.
REQ-035 Reset SHALL clear core_key, core_pt and the result register to 0.
REQ-036 During and immediately after reset: core_start=0, out_valid=0, out_last=0, out_data=0, timeout_err=0, busy=0, in_ready=1 from the first cycle after reset deasserts.
REQ-037 Reset asserted mid-job in any state SHALL discard the partial job; no core_start or out_valid pulse is emitted afterwards for it.

Verification
REQ-038 FIPS-197 vector: key words 00010203,04050607,08090a0b,0c0d0e0f, then pt 00112233,44556677,8899aabb,ccddeeff; core model returns 69c4e0d86a7b0430d8cdb78070b4c55a after 20 cycles -> out_data 69c4e0d8,6a7b0430,d8cdb780,70b4c55a; out_last on the 4th; core_start exactly once.
REQ-039 Gapped input: in_valid toggled randomly across the 8 words -> same core_key/core_pt; core_start 1 cycle after the 8th accepted word.
REQ-040 Backpressure: out_ready low for 5 cycles on word 2 -> out_data holds d8cdb780 stable, no word lost or duplicated; in_ready stays 0 until the last word is accepted.
REQ-041 Timeout: core_done never asserted -> timeout_err pulses once, TIMEOUT cycles after WAIT entry; out_valid never asserts; in_ready=1 the next cycle.
REQ-042 Corner cases: core_done on the final timeout cycle -> DRAIN with no timeout_err; spurious core_done in LOAD -> ignored.
REQ-043 Reset after 5 accepted words, then a full new job -> output corresponds only to the new job.
